// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, word width, access op encoding.
package dmem_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Encoding is {write, read}, so a simultaneous read+write becomes a swap.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic rd, input logic wr);
        return op_e'({wr, rd});
    endfunction

    function automatic logic op_reads(input op_e op);
        return (op == OP_LOAD) || (op == OP_SWAP);
    endfunction

    function automatic logic op_writes(input op_e op);
        return (op == OP_STORE) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between pipeline (master) and responder (slave).
// misalign_o exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemRead_i;
    logic              MemWrite_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] wdata_i;
    logic [WORD_W-1:0] ReadData_o;
    logic              stall_o;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              misalign_o;

    modport master (output MemRead_i, MemWrite_i, addr_i, wdata_i,
                    input  ReadData_o, stall_o, misalign_o);
    modport slave  (input  MemRead_i, MemWrite_i, addr_i, wdata_i,
                    output ReadData_o, stall_o, misalign_o);
`else
    modport master (output MemRead_i, MemWrite_i, addr_i, wdata_i,
                    input  ReadData_o, stall_o);
    modport slave  (input  MemRead_i, MemWrite_i, addr_i, wdata_i,
                    output ReadData_o, stall_o);
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port 2^DEPTH_W x WORD_W synchronous RAM: registered read, read-before-write.
// The read register only updates on re_i, so it holds the last loaded word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               re_i,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic [WORD_W-1:0]  wdata_i,
    output logic [WORD_W-1:0]  rdata_o
);

    logic [WORD_W-1:0] mem_q [0:(1<<DEPTH_W)-1];
    logic [WORD_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline LATENCY cycles per access.
// Optional alignment check under DMEM_ALIGN_CHECK_EN (drops misaligned requests).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_W = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    op_e                  op_q, op_d;
    logic [DEPTH_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;

    logic                 req;
    logic                 drop_req;
    logic                 stall;
    logic                 ram_re, ram_we;
    logic [DEPTH_W-1:0]   ram_addr;
    logic [WORD_W-1:0]    ram_wdata;
    logic [WORD_W-1:0]    ram_rdata;
    logic                 unused_addr_bits;

    assign req = bus.MemRead_i | bus.MemWrite_i;
    assign unused_addr_bits = ^{bus.addr_i[WORD_W-1:DEPTH_W+2], bus.addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign drop_req       = |bus.addr_i[1:0];
    assign bus.misalign_o = (state_q == IDLE) && req && drop_req;
`else
    assign drop_req = 1'b0;
`endif

    // The RAM is accessed on the edge that enters DONE, so its registered
    // read output is valid in DONE and the store commits on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        stall     = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (req && !drop_req) begin
                    stall   = 1'b1;
                    op_d    = decode_op(bus.MemRead_i, bus.MemWrite_i);
                    addr_d  = bus.addr_i[DEPTH_W+1:2];
                    wdata_d = bus.wdata_i;
                    cnt_d   = LAT_INIT;
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        ram_re    = op_reads(op_d);
                        ram_we    = op_writes(op_d);
                        ram_addr  = addr_d;
                        ram_wdata = wdata_d;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = DONE;
                    ram_re  = op_reads(op_q);
                    ram_we  = op_writes(op_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Reset on the commit edge discards the pending access.
    dmem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (ram_re & ~rst_i),
        .we_i    (ram_we & ~rst_i),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.ReadData_o = ram_rdata;
    assign bus.stall_o    = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance (u0) and LATENCY=1 instance (u1).
// Alignment-check scenario is built only with DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder_if b0();
    dmem_responder_if b1();

    dmem_responder #(.DEPTH_W(8), .LATENCY(2)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));
    dmem_responder #(.DEPTH_W(8), .LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

    function automatic logic stall_of(input bit sel);
        return sel ? b1.stall_o : b0.stall_o;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? b1.ReadData_o : b0.ReadData_o;
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b1.MemRead_i = rd; b1.MemWrite_i = wr; b1.addr_i = a; b1.wdata_i = d;
        end else begin
            b0.MemRead_i = rd; b0.MemWrite_i = wr; b0.addr_i = a; b0.wdata_i = d;
        end
    endtask

    // Called just after a negedge; returns just after a later negedge in IDLE.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rd_done,
                          output logic [31:0] rd_after);
        stalls = 0;
        drive(sel, rd, wr, a, d);
        #1;
        while (stall_of(sel) === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk); #1;
        end
        rd_done = rdata_of(sel);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        rd_after = rdata_of(sel);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (b0.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall0: got %b expected 0", b0.stall_o); end
        n_checks++; if (b0.ReadData_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 00000000", b0.ReadData_o); end
        n_checks++; if (b1.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall1: got %b expected 0", b1.stall_o); end
        n_checks++; if (b1.ReadData_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1: got %h expected 00000000", b1.ReadData_o); end
`ifdef DMEM_ALIGN_CHECK_EN
        n_checks++; if (b0.misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", b0.misalign_o); end
`endif
    endtask

    task automatic test_store();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, rdd, rda);
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL store_stall: got %0d expected 2", st); end
        n_checks++; if (rdd !== 32'h0) begin n_fail++; $display("FAIL store_rdata_done: got %h expected 00000000", rdd); end
        n_checks++; if (rda !== 32'h0) begin n_fail++; $display("FAIL store_rdata_after: got %h expected 00000000", rda); end
    endtask

    task automatic test_load();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, st, rdd, rda);
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL load_stall: got %0d expected 2", st); end
        n_checks++; if (rdd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_done: got %h expected deadbeef", rdd); end
        n_checks++; if (rda !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_hold: got %h expected deadbeef", rda); end
    endtask

    task automatic test_alias();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b1, 1'b0, 32'h410, 32'h0, st, rdd, rda);
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL alias_stall: got %0d expected 2", st); end
        n_checks++; if (rdd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alias_410: got %h expected deadbeef", rdd); end
        access(1'b0, 1'b1, 1'b0, 32'hFFFFF012, 32'h0, st, rdd, rda);
        n_checks++; if (rdd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alias_high_low_bits: got %h expected deadbeef", rdd); end
    endtask

    task automatic test_read_write_both();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h1, st, rdd, rda);
        n_checks++; if (rdd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_keeps_rdata: got %h expected deadbeef", rdd); end
        access(1'b0, 1'b1, 1'b1, 32'h40, 32'h2, st, rdd, rda);
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL both_stall: got %0d expected 2", st); end
        n_checks++; if (rdd !== 32'h1) begin n_fail++; $display("FAIL both_prewrite: got %h expected 00000001", rdd); end
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, st, rdd, rda);
        n_checks++; if (rdd !== 32'h2) begin n_fail++; $display("FAIL both_written: got %h expected 00000002", rdd); end
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, st, rdd, rda);
        n_checks++; if (rdd !== 32'h2) begin n_fail++; $display("FAIL b2b_store_rdata: got %h expected 00000002", rdd); end
        access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, st, rdd, rda);
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL b2b_load_stall: got %0d expected 2", st); end
        n_checks++; if (rdd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_load_rdata: got %h expected a5a5a5a5", rdd); end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        int st; logic [31:0] rdd, rda;
        drive(1'b0, 1'b0, 1'b1, 32'h13, 32'h77);
        #1;
        n_checks++; if (b0.misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse: got %b expected 1", b0.misalign_o); end
        n_checks++; if (b0.stall_o !== 1'b0) begin n_fail++; $display("FAIL misalign_nostall: got %b expected 0", b0.stall_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++; if (b0.misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b expected 0", b0.misalign_o); end
        n_checks++; if (b0.stall_o !== 1'b0) begin n_fail++; $display("FAIL misalign_stay_idle: got %b expected 0", b0.stall_o); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, st, rdd, rda);
        n_checks++; if (rdd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL misalign_no_write: got %h expected deadbeef", rdd); end
    endtask
`endif

    task automatic test_reset_mid_access();
        int st; logic [31:0] rdd, rda;
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234, st, rdd, rda);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h55);
        #1;
        n_checks++; if (b0.stall_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept_stall: got %b expected 1", b0.stall_o); end
        @(negedge clk); #1;
        n_checks++; if (b0.stall_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_stall: got %b expected 1", b0.stall_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++; if (b0.stall_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall_cleared: got %b expected 0", b0.stall_o); end
        n_checks++; if (b0.ReadData_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata_cleared: got %h expected 00000000", b0.ReadData_o); end
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, st, rdd, rda);
        n_checks++; if (rdd !== 32'h1234) begin n_fail++; $display("FAIL rstmid_store_discarded: got %h expected 00001234", rdd); end
    endtask

    task automatic test_latency1();
        int st; logic [31:0] rdd, rda;
        access(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, st, rdd, rda);
        n_checks++; if (st != 1) begin n_fail++; $display("FAIL lat1_store_stall: got %0d expected 1", st); end
        n_checks++; if (rdd !== 32'h0) begin n_fail++; $display("FAIL lat1_store_rdata: got %h expected 00000000", rdd); end
        access(1'b1, 1'b1, 1'b0, 32'h408, 32'h0, st, rdd, rda);
        n_checks++; if (st != 1) begin n_fail++; $display("FAIL lat1_load_stall: got %0d expected 1", st); end
        n_checks++; if (rdd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat1_load_alias: got %h expected cafef00d", rdd); end
        n_checks++; if (rda !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat1_load_hold: got %h expected cafef00d", rda); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_alias();
        test_read_write_both();
        test_back_to_back();
`ifdef DMEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_mid_access();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
